// File: rtl/cm_pkg.sv
// Shared typedefs and helpers for the lib_cm delay-line and pipeline blocks.
package cm_pkg;

   typedef enum logic [0:0] {SHREG_RST_NONE, SHREG_RST_ALL} t_shreg_rst;

   typedef enum logic [0:0] {PIPE_RST_VLD, PIPE_RST_ALL} t_pipe_rst;

   // Occupancy counter width; a bypass pipe still exposes a 1-bit count.
   function automatic int unsigned pipe_occ_width(input int unsigned len);
      return (len == 0) ? 1 : $clog2(len + 1);
   endfunction

endpackage

// File: rtl/cm_pipe_stage.sv
// One elastic pipeline stage: valid flag plus payload, loaded when i_en is high.
module cm_pipe_stage
   import cm_pkg::*;
#(
   parameter type       DTYPE    = logic [7:0],
   parameter t_pipe_rst RST_MODE = PIPE_RST_VLD
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_vld,
   input  DTYPE i_data,
   output logic o_vld,
   output DTYPE o_data
);

   logic vld_q, vld_d;
   DTYPE data_q, data_d;

   // Payload only moves with a valid item so bubbles do not toggle the register.
   always_comb begin
      vld_d  = i_en ? i_vld : vld_q;
      data_d = (i_en && i_vld) ? i_data : data_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_q <= 1'b0;
         if (RST_MODE == PIPE_RST_ALL) data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign o_vld  = vld_q;
   assign o_data = data_q;

endmodule

// File: rtl/cm_pipe_elastic.sv
// Elastic valid/ready pipeline of LEN stages with collapsing bubbles; LEN = 0 is a wire.
// Define CM_PIPE_ELASTIC_OCC_EN to add the o_occ occupancy output.
module cm_pipe_elastic
   import cm_pkg::*;
#(
   parameter int unsigned LEN      = 2,
   parameter type         DTYPE    = logic [7:0],
   parameter t_pipe_rst   RST_MODE = PIPE_RST_VLD
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vld,
   output logic o_rdy,
   input  DTYPE i_data,
   output logic o_vld,
   input  logic i_rdy,
   output DTYPE o_data
`ifdef CM_PIPE_ELASTIC_OCC_EN
   ,
   output logic [pipe_occ_width(LEN)-1:0] o_occ
`endif
);

   generate
      if (LEN == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = i_clk ^ i_rst_n;
         assign o_vld  = i_vld;
         assign o_data = i_data;
         assign o_rdy  = i_rdy;
`ifdef CM_PIPE_ELASTIC_OCC_EN
         assign o_occ  = '0;
`endif
      end else begin : g_pipe
         logic [LEN-1:0] stg_vld;
         DTYPE           stg_data [LEN];

         for (genvar k = 0; k < LEN; k++) begin : g_stage
            logic en;
            logic prev_vld;
            DTYPE prev_data;

            if (k == 0) begin : g_head
               assign prev_vld  = i_vld;
               assign prev_data = i_data;
            end else begin : g_link
               assign prev_vld  = stg_vld[k-1];
               assign prev_data = stg_data[k-1];
            end

            // A stage may load if it is empty or everything ahead of it can move.
            if (k == LEN - 1) begin : g_tail
               assign en = !stg_vld[k] || i_rdy;
            end else begin : g_mid
               assign en = !stg_vld[k] || g_stage[k+1].en;
            end

            cm_pipe_stage #(
               .DTYPE    (DTYPE),
               .RST_MODE (RST_MODE)
            ) u_stage (
               .i_clk   (i_clk),
               .i_rst_n (i_rst_n),
               .i_en    (en),
               .i_vld   (prev_vld),
               .i_data  (prev_data),
               .o_vld   (stg_vld[k]),
               .o_data  (stg_data[k])
            );
         end

         // Gate with reset so the handshake is quiet before the clearing edge.
         assign o_vld  = stg_vld[LEN-1] && i_rst_n;
         assign o_data = stg_data[LEN-1];
         assign o_rdy  = g_stage[0].en && i_rst_n;

`ifdef CM_PIPE_ELASTIC_OCC_EN
         localparam int unsigned OCC_W = pipe_occ_width(LEN);
         assign o_occ = OCC_W'($countones(stg_vld));
`endif
      end
   endgenerate

endmodule
